// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, requests to send, then shifts
// one byte, odd parity and stop out on device clock falls and checks the device ACK.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int FILTER_LEN     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       kb_clk_in,
    input  logic       kb_data_in,
    output logic       kb_clk_drive_low,
    output logic       kb_data_drive_low
);

    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int FLT_W   = $clog2(FILTER_LEN + 1);
    localparam logic [CNT_W-1:0] INHIBIT_LAST    = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] INHIBIT_PRELAST = CNT_W'(INHIBIT_CYCLES - 2);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [FLT_W-1:0] FLT_LAST        = FLT_W'(FILTER_LEN - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_REQ       = 3'd2,
        ST_SEND      = 3'd3,
        ST_ACK       = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } state_t;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

    state_t           state_r, state_next_s;
    logic             clk_meta_r, clk_sync_r, data_meta_r, data_sync_r;
    logic             filt_clk_r, filt_prev_r;
    logic [FLT_W-1:0] flt_cnt_r;
    logic             fall_s, in_frame_s, timeout_s, cnt_clr_s;
    logic [CNT_W-1:0] cnt_r;
    logic [3:0]       bit_cnt_r;
    logic [7:0]       tx_byte_r;
    logic             parity_r;
    logic             busy_r, done_r, error_r, clk_low_r, data_low_r;
    logic             done_s, error_s, data_low_s;

    assign fall_s     = filt_prev_r & ~filt_clk_r;
    assign in_frame_s = (state_r == ST_SEND) || (state_r == ST_ACK) || (state_r == ST_WAIT_IDLE);
    assign timeout_s  = (cnt_r == TIMEOUT_LAST);

    // Two-flop synchronizers; idle lines are high, so reset to 1 to avoid a false edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_meta_r  <= 1'b1;
            clk_sync_r  <= 1'b1;
            data_meta_r <= 1'b1;
            data_sync_r <= 1'b1;
        end else begin
            clk_meta_r  <= kb_clk_in;
            clk_sync_r  <= clk_meta_r;
            data_meta_r <= kb_data_in;
            data_sync_r <= data_meta_r;
        end
    end

    // Clock stability filter: the level only follows after FILTER_LEN differing samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_clk_r  <= 1'b1;
            filt_prev_r <= 1'b1;
            flt_cnt_r   <= {FLT_W{1'b0}};
        end else begin
            filt_prev_r <= filt_clk_r;
            if (clk_sync_r == filt_clk_r) begin
                flt_cnt_r <= {FLT_W{1'b0}};
            end else if (flt_cnt_r == FLT_LAST) begin
                filt_clk_r <= clk_sync_r;
                flt_cnt_r  <= {FLT_W{1'b0}};
            end else begin
                flt_cnt_r <= flt_cnt_r + FLT_W'(1);
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; a device clock fall always takes priority over the timeout.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE:      state_next_s = tx_start ? ST_INHIBIT : ST_IDLE;
            ST_INHIBIT:   state_next_s = (cnt_r == INHIBIT_LAST) ? ST_REQ : ST_INHIBIT;
            ST_REQ:       state_next_s = ST_SEND;
            ST_SEND: begin
                if (fall_s) begin
                    state_next_s = (bit_cnt_r == 4'd9) ? ST_ACK : ST_SEND;
                end else begin
                    state_next_s = timeout_s ? ST_IDLE : ST_SEND;
                end
            end
            ST_ACK: begin
                if (fall_s) begin
                    state_next_s = data_sync_r ? ST_IDLE : ST_WAIT_IDLE;
                end else begin
                    state_next_s = timeout_s ? ST_IDLE : ST_ACK;
                end
            end
            ST_WAIT_IDLE: begin
                if (clk_sync_r && data_sync_r) begin
                    state_next_s = ST_IDLE;
                end else if (fall_s) begin
                    state_next_s = ST_WAIT_IDLE;
                end else begin
                    state_next_s = timeout_s ? ST_IDLE : ST_WAIT_IDLE;
                end
            end
            default:      state_next_s = ST_IDLE;
        endcase
    end

    // Output logic: next values of the registered line drives and status pulses.
    always_comb begin
        done_s     = (state_r == ST_WAIT_IDLE) && clk_sync_r && data_sync_r;
        error_s    = in_frame_s && (state_next_s == ST_IDLE) && !done_s;
        data_low_s = 1'b0;
        cnt_clr_s  = (state_r == ST_IDLE) || (state_next_s != state_r) || (fall_s && in_frame_s);
        case (state_r)
            ST_INHIBIT: data_low_s = (cnt_r >= INHIBIT_PRELAST);
            ST_REQ:     data_low_s = 1'b1;
            ST_SEND: begin
                if (fall_s) begin
                    case (bit_cnt_r)
                        4'd8:    data_low_s = ~parity_r;
                        4'd9:    data_low_s = 1'b0;
                        default: data_low_s = ~tx_byte_r[bit_cnt_r[2:0]];
                    endcase
                end else if (timeout_s) begin
                    data_low_s = 1'b0;
                end else begin
                    data_low_s = data_low_r;
                end
            end
            default:    data_low_s = 1'b0;
        endcase
    end

    // Datapath: cycle/timeout counter, edge counter and the latched byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r     <= {CNT_W{1'b0}};
            bit_cnt_r <= 4'd0;
            tx_byte_r <= 8'd0;
            parity_r  <= 1'b0;
        end else begin
            cnt_r <= cnt_clr_s ? {CNT_W{1'b0}} : (cnt_r + CNT_W'(1));
            if (state_r == ST_IDLE && tx_start) begin
                tx_byte_r <= tx_data;
                parity_r  <= odd_parity(tx_data);
            end else begin
                tx_byte_r <= tx_byte_r;
                parity_r  <= parity_r;
            end
            if (state_r == ST_REQ || state_r == ST_IDLE) begin
                bit_cnt_r <= 4'd0;
            end else if (state_r == ST_SEND && fall_s) begin
                bit_cnt_r <= bit_cnt_r + 4'd1;
            end else begin
                bit_cnt_r <= bit_cnt_r;
            end
        end
    end

    // Registered outputs; Done/Error land on the IDLE entry cycle together with Busy falling.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            error_r    <= 1'b0;
            clk_low_r  <= 1'b0;
            data_low_r <= 1'b0;
        end else begin
            busy_r     <= (state_next_s != ST_IDLE);
            done_r     <= done_s;
            error_r    <= error_s;
            clk_low_r  <= (state_next_s == ST_INHIBIT);
            data_low_r <= data_low_s;
        end
    end

    assign tx_busy           = busy_r;
    assign tx_done           = done_r;
    assign tx_error          = error_r;
    assign kb_clk_drive_low  = clk_low_r;
    assign kb_data_drive_low = data_low_r;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the host and a
// frame-level reference (start, LSB-first data, odd parity, stop) checks every bit.
module tb_ps2_host_tx;

    localparam int INH = 60;
    localparam int TO  = 2000;
    localparam int FL  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_start = 1'b0;
    logic       tx_busy, tx_done, tx_error;
    logic       kb_clk_drive_low, kb_data_drive_low;
    logic       kb_clk_in, kb_data_in;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       glitch = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int cyc      = 0;
    int err_cyc  = 0;
    logic prev_busy = 1'b0;

    // Open-drain wired-AND of host, device and glitch injector.
    assign kb_clk_in  = ~(kb_clk_drive_low | dev_clk_low | glitch);
    assign kb_data_in = ~(kb_data_drive_low | dev_data_low);

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO), .FILTER_LEN(FL)) dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_start(tx_start),
        .tx_busy(tx_busy), .tx_done(tx_done), .tx_error(tx_error),
        .kb_clk_in(kb_clk_in), .kb_data_in(kb_data_in),
        .kb_clk_drive_low(kb_clk_drive_low), .kb_data_drive_low(kb_data_drive_low)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input longint act, input longint lo, input longint hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_errors++;
            $display("FAIL %s: actual=%0d expected in [%0d,%0d]", name, act, lo, hi);
        end
    endtask

    // Frame as seen on the data line, index 0 = start bit ... 10 = stop bit.
    function automatic logic [10:0] model_frame(input logic [7:0] d);
        int ones = 0;
        logic [10:0] f;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = d[i];
        f[9]  = ((ones % 2) == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    // Per-cycle rules: exclusive pulses, pulses only on the busy-falling cycle, idle lines released.
    task automatic monitor();
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                prev_busy = 1'b0;
            end else begin
                check("done_error_exclusive", longint'(tx_done & tx_error), 0);
                if (tx_done || tx_error) begin
                    check("pulse_with_busy_low", longint'(tx_busy), 0);
                    check("pulse_after_busy", longint'(prev_busy), 1);
                end
                if (tx_done) done_cnt++;
                if (tx_error) begin
                    err_cnt++;
                    err_cyc = cyc;
                end
                if (!tx_busy) check("idle_lines_released", longint'({kb_clk_drive_low, kb_data_drive_low}), 0);
                prev_busy = tx_busy;
            end
        end
    endtask

    task automatic start_tx(input logic [7:0] d);
        @(negedge clk);
        tx_data  = d;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        tx_data  = 8'($urandom);
        check("busy_after_accept", longint'(tx_busy), 1);
    endtask

    task automatic host_request(input logic start_exp);
        int n = 0;
        int low = 0;
        logic last_dlow = 1'b0;
        while (!kb_clk_drive_low && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("inhibit_begins", longint'(kb_clk_drive_low), 1);
        while (kb_clk_drive_low && low < INH + 20) begin
            last_dlow = kb_data_drive_low;
            @(negedge clk);
            low++;
        end
        check_range("inhibit_length", low, INH, INH + 19);
        check("start_bit_in_final_inhibit", longint'(last_dlow), 1);
        check("req_data_low", longint'(kb_data_drive_low), 1);
        repeat (20) @(negedge clk);
        check("start_bit", longint'(kb_data_in), longint'(start_exp));
    endtask

    task automatic dev_pulse(input int half, input logic ack_low, input logic do_glitch, output logic sampled);
        dev_clk_low = 1'b1;
        if (ack_low) dev_data_low = 1'b1;
        repeat (half) @(negedge clk);
        sampled = kb_data_in;
        dev_clk_low = 1'b0;
        if (do_glitch) begin
            repeat (half / 2) @(negedge clk);
            glitch = 1'b1;
            repeat (2) @(negedge clk);
            glitch = 1'b0;
            repeat (half - half / 2 - 2) @(negedge clk);
        end else begin
            repeat (half) @(negedge clk);
        end
        dev_data_low = 1'b0;
    endtask

    task automatic wait_outcome(input int bd, input int be);
        int n = 0;
        while (done_cnt == bd && err_cnt == be && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("outcome_within_bound", longint'(done_cnt != bd || err_cnt != be), 1);
    endtask

    task automatic run_frame(input logic [7:0] d, input int half, input logic ack,
                             input int glitch_pulse, input logic poke);
        logic [10:0] exp;
        logic s;
        int bd, be;
        exp = model_frame(d);
        bd  = done_cnt;
        be  = err_cnt;
        start_tx(d);
        host_request(exp[0]);
        for (int p = 1; p <= 10; p++) begin
            dev_pulse(half, 1'b0, (p == glitch_pulse), s);
            check($sformatf("frame_%02h_bit%0d", d, p), longint'(s), longint'(exp[p]));
            if (poke && p == 2) begin
                tx_data  = 8'h55;
                tx_start = 1'b1;
                @(negedge clk);
                tx_start = 1'b0;
            end
        end
        dev_pulse(half, ack, 1'b0, s);
        wait_outcome(bd, be);
        repeat (2) @(negedge clk);
        check($sformatf("frame_%02h_done_count", d), done_cnt - bd, ack ? 1 : 0);
        check($sformatf("frame_%02h_error_count", d), err_cnt - be, ack ? 0 : 1);
        check("busy_low_after_frame", longint'(tx_busy), 0);
        check("lines_released_after_frame", longint'({kb_clk_drive_low, kb_data_drive_low}), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        logic s;
        int bd, be, t0, seen;
        fork
            monitor();
        join_none

        repeat (3) @(negedge clk);
        check("reset_busy", longint'(tx_busy), 0);
        check("reset_done", longint'(tx_done), 0);
        check("reset_error", longint'(tx_error), 0);
        check("reset_drives", longint'({kb_clk_drive_low, kb_data_drive_low}), 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        check("model_ED", longint'(model_frame(8'hED)), longint'({1'b1, 1'b1, 8'hED, 1'b0}));
        check("model_07", longint'(model_frame(8'h07)), longint'({1'b1, 1'b0, 8'h07, 1'b0}));
        check("model_00", longint'(model_frame(8'h00)), longint'({1'b1, 1'b1, 8'h00, 1'b0}));
        check("model_FF", longint'(model_frame(8'hFF)), longint'({1'b1, 1'b1, 8'hFF, 1'b0}));

        run_frame(8'hED, 20, 1'b1, 0, 1'b0);
        run_frame(8'h07, 20, 1'b1, 0, 1'b0);
        run_frame(8'h00, 20, 1'b1, 0, 1'b0);
        run_frame(8'h3C, 20, 1'b0, 0, 1'b0);

        // Device goes silent after 4 edges.
        bd = done_cnt;
        be = err_cnt;
        start_tx(8'hA5);
        host_request(1'b0);
        for (int p = 1; p <= 3; p++) dev_pulse(20, 1'b0, 1'b0, s);
        t0 = cyc;
        dev_pulse(20, 1'b0, 1'b0, s);
        seen = 0;
        while (err_cnt == be && seen < TO + 200) begin
            @(negedge clk);
            seen++;
        end
        check("timeout_error_count", err_cnt - be, 1);
        check("timeout_no_done", done_cnt - bd, 0);
        check_range("timeout_latency", err_cyc - t0, TO + FL + 1, TO + FL + 5);
        check("timeout_lines_released", longint'({kb_clk_drive_low, kb_data_drive_low}), 0);

        // Reset while bit 5 (a 0) is being driven.
        bd = done_cnt;
        be = err_cnt;
        start_tx(8'h00);
        host_request(1'b0);
        for (int p = 1; p <= 4; p++) dev_pulse(20, 1'b0, 1'b0, s);
        dev_clk_low = 1'b1;
        repeat (12) @(negedge clk);
        check("bit5_driven_low", longint'(kb_data_drive_low), 1);
        rst = 1'b1;
        #1;
        check("reset_mid_drives", longint'({kb_clk_drive_low, kb_data_drive_low}), 0);
        check("reset_mid_busy", longint'(tx_busy), 0);
        check("reset_mid_pulses", longint'({tx_done, tx_error}), 0);
        repeat (3) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (50) @(negedge clk);
        check("reset_mid_no_done", done_cnt - bd, 0);
        check("reset_mid_no_error", err_cnt - be, 0);
        run_frame(8'hFF, 20, 1'b1, 0, 1'b0);

        // Start request while busy is dropped; a short clock glitch must not advance bits.
        run_frame(8'hF4, 20, 1'b1, 3, 1'b1);
        seen = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (kb_clk_drive_low || tx_busy) seen++;
        end
        check("no_queued_frame", seen, 0);

        for (int k = 0; k < 4; k++) begin
            run_frame(8'($urandom), int'($urandom_range(16, 28)), 1'b1, int'($urandom_range(0, 9)), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
